// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: parametrised single-clock FIFO with programmable almost-full and
// almost-empty levels, an occupancy count, an optional first-word-fall-through
// read port and sticky overflow/underflow flags.
module sync_fifo_pro #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter bit FWFT       = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FIFO_WIDTH-1:0]             data_in,
  input  logic                              wr_en,
  input  logic                              rd_en,
  input  logic                              err_clr,
  output logic [FIFO_WIDTH-1:0]             data_out,
  output logic                              rd_valid,
  output logic                              wr_ack,
  output logic                              overflow,
  output logic                              underflow,
  output logic                              full,
  output logic                              empty,
  output logic                              almostfull,
  output logic                              almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              ovf_sticky,
  output logic                              udf_sticky
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  if (!((AE_LEVEL > 0) && (AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= FIFO_DEPTH))) begin : g_bad_levels
    $error("sync_fifo_pro: levels must satisfy 0 < AE_LEVEL < AF_LEVEL <= FIFO_DEPTH");
  end

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  rvld_q, wr_ack_q, ovf_q, udf_q;
  logic                  ovs_q, ovs_d, uds_q, uds_d;
  logic                  full_w, empty_w, wr_acc, rd_acc;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);
  assign wr_acc  = wr_en && !full_w;
  assign rd_acc  = rd_en && !empty_w;

  // Next-state for pointers, occupancy, registered read data and sticky flags.
  always_comb begin
    wr_ptr_d = wr_acc ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_acc ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    dout_d = dout_q;
    if (!FWFT && rd_acc) dout_d = mem[rd_ptr_q];
    // A new error on the same edge as err_clr keeps the flag set.
    ovs_d = (wr_en && full_w)  || (ovs_q && !err_clr);
    uds_d = (rd_en && empty_w) || (uds_q && !err_clr);
  end

  // Control and output registers; rst overrides every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      rvld_q   <= 1'b0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ovs_q    <= 1'b0;
      uds_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      rvld_q   <= rd_acc && !FWFT;
      wr_ack_q <= wr_acc;
      ovf_q    <= wr_en && full_w;
      udf_q    <= rd_en && empty_w;
      ovs_q    <= ovs_d;
      uds_q    <= uds_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data_in;
  end

  // In FWFT mode the head word is presented combinationally from storage.
  assign data_out    = FWFT ? (empty_w ? '0 : mem[rd_ptr_q]) : dout_q;
  assign rd_valid    = FWFT ? !empty_w : rvld_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
  assign full        = full_w;
  assign empty       = empty_w;
  assign almostfull  = (count_q >= AF_C) && (count_q < DEPTH_C);
  assign almostempty = !empty_w && (count_q <= AE_C);
  assign count       = count_q;
  assign ovf_sticky  = ovs_q;
  assign udf_sticky  = uds_q;

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Bench for sync_fifo_pro: three instances share one input stream
//   A: depth 8, FWFT=0, default levels
//   B: depth 6, FWFT=0, default levels
//   C: depth 8, FWFT=1, AF_LEVEL=6, AE_LEVEL=2
// A queue-based reference model tracks depth-8 and depth-6 occupancy.
module tb_sync_fifo_pro;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en, err_clr;
  logic [15:0] data_in;

  logic [15:0] a_dout, b_dout, c_dout;
  logic a_rvld, a_wrack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae, a_ovs, a_uds;
  logic b_rvld, b_wrack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae, b_ovs, b_uds;
  logic c_rvld, c_wrack, c_ovf, c_udf, c_full, c_empty, c_af, c_ae, c_ovs, c_uds;
  logic [3:0] a_cnt, c_cnt;
  logic [2:0] b_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_fifo_pro #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b0)) u_a (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
    .data_out(a_dout), .rd_valid(a_rvld), .wr_ack(a_wrack), .overflow(a_ovf), .underflow(a_udf),
    .full(a_full), .empty(a_empty), .almostfull(a_af), .almostempty(a_ae), .count(a_cnt),
    .ovf_sticky(a_ovs), .udf_sticky(a_uds));

  sync_fifo_pro #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .FWFT(1'b0)) u_b (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
    .data_out(b_dout), .rd_valid(b_rvld), .wr_ack(b_wrack), .overflow(b_ovf), .underflow(b_udf),
    .full(b_full), .empty(b_empty), .almostfull(b_af), .almostempty(b_ae), .count(b_cnt),
    .ovf_sticky(b_ovs), .udf_sticky(b_uds));

  sync_fifo_pro #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1)) u_c (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
    .data_out(c_dout), .rd_valid(c_rvld), .wr_ack(c_wrack), .overflow(c_ovf), .underflow(c_udf),
    .full(c_full), .empty(c_empty), .almostfull(c_af), .almostempty(c_ae), .count(c_cnt),
    .ovf_sticky(c_ovs), .udf_sticky(c_uds));

  // ---------------- reference model ----------------
  logic [15:0] q8[$];
  logic [15:0] q6[$];
  logic [15:0] m_dout [2] = '{16'h0, 16'h0};
  logic        m_rvld [2] = '{1'b0, 1'b0};
  logic        m_wrack[2] = '{1'b0, 1'b0};
  logic        m_ovf  [2] = '{1'b0, 1'b0};
  logic        m_udf  [2] = '{1'b0, 1'b0};
  logic        m_ovs  [2] = '{1'b0, 1'b0};
  logic        m_uds  [2] = '{1'b0, 1'b0};

  task automatic model_step(input int idx, input int depth);
    int n;
    logic is_full, is_empty, wa, ra;
    n = (idx == 0) ? q8.size() : q6.size();
    if (rst) begin
      if (idx == 0) q8.delete(); else q6.delete();
      m_dout[idx] = 16'h0; m_rvld[idx] = 1'b0; m_wrack[idx] = 1'b0;
      m_ovf[idx] = 1'b0; m_udf[idx] = 1'b0; m_ovs[idx] = 1'b0; m_uds[idx] = 1'b0;
    end else begin
      is_full  = (n == depth);
      is_empty = (n == 0);
      wa = wr_en && !is_full;
      ra = rd_en && !is_empty;
      m_rvld[idx] = ra;
      if (ra) begin
        if (idx == 0) m_dout[idx] = q8.pop_front();
        else          m_dout[idx] = q6.pop_front();
      end
      if (wa) begin
        if (idx == 0) q8.push_back(data_in);
        else          q6.push_back(data_in);
      end
      m_wrack[idx] = wa;
      m_ovf[idx]   = wr_en && is_full;
      m_udf[idx]   = rd_en && is_empty;
      m_ovs[idx]   = m_ovf[idx] || (m_ovs[idx] && !err_clr);
      m_uds[idx]   = m_udf[idx] || (m_uds[idx] && !err_clr);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input int idx, input int depth, input int af, input int ae,
                         input bit fwft, input logic [15:0] dout, input logic rvld, input logic wrack,
                         input logic ovf, input logic udf, input logic fl, input logic em,
                         input logic afo, input logic aeo, input int cnt, input logic ovs, input logic uds);
    int n;
    logic [15:0] front;
    n = (idx == 0) ? q8.size() : q6.size();
    front = 16'h0;
    if (n != 0) front = (idx == 0) ? q8[0] : q6[0];
    chk({tag, "_count"}, cnt, n);
    chk({tag, "_full"}, int'(fl), int'(n == depth));
    chk({tag, "_empty"}, int'(em), int'(n == 0));
    chk({tag, "_almostfull"}, int'(afo), int'(n >= af && n < depth));
    chk({tag, "_almostempty"}, int'(aeo), int'(n > 0 && n <= ae));
    chk({tag, "_wr_ack"}, int'(wrack), int'(m_wrack[idx]));
    chk({tag, "_overflow"}, int'(ovf), int'(m_ovf[idx]));
    chk({tag, "_underflow"}, int'(udf), int'(m_udf[idx]));
    chk({tag, "_ovf_sticky"}, int'(ovs), int'(m_ovs[idx]));
    chk({tag, "_udf_sticky"}, int'(uds), int'(m_uds[idx]));
    chk({tag, "_data_out"}, int'(dout), fwft ? int'(front) : int'(m_dout[idx]));
    chk({tag, "_rd_valid"}, int'(rvld), fwft ? int'(n != 0) : int'(m_rvld[idx]));
  endtask

  task automatic drive(input logic r, input logic w, input logic rd, input logic c, input logic [15:0] d);
    rst = r; wr_en = w; rd_en = rd; err_clr = c; data_in = d;
  endtask

  // One clock: model follows the edge, all instances compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step(0, 8);
    model_step(1, 6);
    #1;
    cmp_all("A", 0, 8, 7, 1, 1'b0, a_dout, a_rvld, a_wrack, a_ovf, a_udf, a_full, a_empty,
            a_af, a_ae, int'(a_cnt), a_ovs, a_uds);
    cmp_all("B", 1, 6, 5, 1, 1'b0, b_dout, b_rvld, b_wrack, b_ovf, b_udf, b_full, b_empty,
            b_af, b_ae, int'(b_cnt), b_ovs, b_uds);
    cmp_all("C", 0, 8, 6, 2, 1'b1, c_dout, c_rvld, c_wrack, c_ovf, c_udf, c_full, c_empty,
            c_af, c_ae, int'(c_cnt), c_ovs, c_uds);
  endtask

  // ---------------- directed table for instance A ----------------
  typedef struct {
    logic r, w, rd, clr;
    logic [15:0] din;
    int cnt;
    logic fl, em, af, ae, wrack, ovf, udf, rvld, ovs, uds;
    logic [15:0] dout;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic clr,
                              input logic [15:0] din, input int cnt, input logic fl, input logic em,
                              input logic af, input logic ae, input logic wrack, input logic ovf,
                              input logic udf, input logic rvld, input logic ovs, input logic uds,
                              input logic [15:0] dout);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.clr = clr; v.din = din; v.cnt = cnt;
    v.fl = fl; v.em = em; v.af = af; v.ae = ae; v.wrack = wrack; v.ovf = ovf;
    v.udf = udf; v.rvld = rvld; v.ovs = ovs; v.uds = uds; v.dout = dout;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    logic [15:0] exp_w;
    // reset, 8 writes, overflow write, 8 reads, underflow read, err_clr
    tbl[0] = mk(1, 0, 0, 0, 16'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 8; i++)
      tbl[i] = mk(0, 1, 0, 0, 16'(i), i, i == 8, 0, i == 7, i == 1, 1, 0, 0, 0, 0, 0, 16'h0);
    tbl[9] = mk(0, 1, 0, 0, 16'h9, 8, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 16'h0);
    for (int k = 1; k <= 8; k++)
      tbl[9+k] = mk(0, 0, 1, 0, 16'h0, 8 - k, 0, k == 8, (8 - k) == 7, (8 - k) == 1,
                    0, 0, 0, 1, 1, 0, 16'(k));
    tbl[18] = mk(0, 0, 1, 0, 16'h0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 16'h8);
    tbl[19] = mk(0, 0, 0, 1, 16'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h8);

    drive(1, 0, 0, 0, 16'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].clr, tbl[i].din);
      tick();
      chk("tbl_count", int'(a_cnt), tbl[i].cnt);
      chk("tbl_full", int'(a_full), int'(tbl[i].fl));
      chk("tbl_empty", int'(a_empty), int'(tbl[i].em));
      chk("tbl_almostfull", int'(a_af), int'(tbl[i].af));
      chk("tbl_almostempty", int'(a_ae), int'(tbl[i].ae));
      chk("tbl_wr_ack", int'(a_wrack), int'(tbl[i].wrack));
      chk("tbl_overflow", int'(a_ovf), int'(tbl[i].ovf));
      chk("tbl_underflow", int'(a_udf), int'(tbl[i].udf));
      chk("tbl_rd_valid", int'(a_rvld), int'(tbl[i].rvld));
      chk("tbl_ovf_sticky", int'(a_ovs), int'(tbl[i].ovs));
      chk("tbl_udf_sticky", int'(a_uds), int'(tbl[i].uds));
      chk("tbl_data_out", int'(a_dout), int'(tbl[i].dout));
    end

    // wrap-around on depth 6 at steady count 3
    drive(1, 0, 0, 0, 16'h0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 16'(16'h10 + i)); tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 1, 0, 16'(16'h100 + i)); tick();
      exp_w = (i < 3) ? 16'(16'h10 + i) : 16'(16'h100 + i - 3);
      chk("wrap_data_out", int'(b_dout), int'(exp_w));
      chk("wrap_count", int'(b_cnt), 3);
      chk("wrap_rd_valid", int'(b_rvld), 1);
      chk("wrap_no_overflow", int'(b_ovf), 0);
      chk("wrap_no_underflow", int'(b_udf), 0);
    end

    // simultaneous write/read at full
    drive(1, 0, 0, 0, 16'h0); tick();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 0, 0, 16'(16'h20 + i)); tick();
    end
    drive(0, 1, 1, 0, 16'h55); tick();
    chk("full_wr_rd_count", int'(a_cnt), 7);
    chk("full_wr_rd_overflow", int'(a_ovf), 1);
    chk("full_wr_rd_data", int'(a_dout), 16'h21);

    // simultaneous write/read at empty, then read the word back
    drive(1, 0, 0, 0, 16'h0); tick();
    drive(0, 1, 1, 0, 16'h77); tick();
    chk("empty_wr_rd_count", int'(a_cnt), 1);
    chk("empty_wr_rd_underflow", int'(a_udf), 1);
    chk("empty_wr_rd_wr_ack", int'(a_wrack), 1);
    drive(0, 0, 1, 0, 16'h0); tick();
    chk("empty_wr_rd_readback", int'(a_dout), 16'h77);
    chk("empty_wr_rd_rvld", int'(a_rvld), 1);

    // FWFT fall-through and pop
    drive(1, 0, 0, 0, 16'h0); tick();
    drive(0, 1, 0, 0, 16'hABCD); tick();
    chk("fwft_data_out", int'(c_dout), 16'hABCD);
    chk("fwft_rd_valid", int'(c_rvld), 1);
    chk("std_no_rd_valid", int'(a_rvld), 0);
    drive(0, 0, 1, 0, 16'h0); tick();
    chk("fwft_pop_empty", int'(c_empty), 1);
    chk("fwft_pop_rd_valid", int'(c_rvld), 0);

    // mid-burst reset at count 5 with ovf_sticky set
    drive(1, 0, 0, 0, 16'h0); tick();
    for (int i = 1; i <= 9; i++) begin
      drive(0, 1, 0, 0, 16'(16'h40 + i)); tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 16'h0); tick();
    end
    chk("pre_rst_count", int'(a_cnt), 5);
    chk("pre_rst_ovf_sticky", int'(a_ovs), 1);
    drive(1, 1, 0, 0, 16'h99); tick();
    chk("rst_count", int'(a_cnt), 0);
    chk("rst_empty", int'(a_empty), 1);
    chk("rst_full", int'(a_full), 0);
    chk("rst_almostempty", int'(a_ae), 0);
    chk("rst_data_out", int'(a_dout), 0);
    chk("rst_rd_valid", int'(a_rvld), 0);
    chk("rst_wr_ack", int'(a_wrack), 0);
    chk("rst_ovf_sticky", int'(a_ovs), 0);

    // err_clr with no error, then err_clr coinciding with overflow
    drive(0, 0, 1, 0, 16'h0); tick();
    chk("udf_sticky_set", int'(a_uds), 1);
    drive(0, 0, 0, 1, 16'h0); tick();
    chk("clr_udf_sticky", int'(a_uds), 0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 0, 16'(i)); tick();
    end
    chk("ovs_before_clr", int'(a_ovs), 1);
    drive(0, 1, 0, 1, 16'h0); tick();
    chk("clr_vs_overflow", int'(a_ovs), 1);
    drive(0, 0, 0, 1, 16'h0); tick();
    chk("clr_ovf_sticky", int'(a_ovs), 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 100) == 0,
            (i < 300) ? ($urandom % 10) < 7 : ($urandom % 10) < 3,
            (i < 300) ? ($urandom % 10) < 3 : ($urandom % 10) < 7,
            ($urandom % 16) == 0,
            16'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
